rob_commit_unit: RTL
====================

Name: rob_commit_unit

Overview:
- Reorder buffer for the out-of-order RISC-V core.
- Allocates tags to dispatched instructions and collects results from the common data bus.
- Commits results in program order to the register file's commit port.
- On a branch mispredict at commit, flushes the machine with clr and a redirect PC.

Parameters:
ROB_SIZE, 32, number of entries (power of two)
TAG_W, 5, tag width = log2(ROB_SIZE); tag is the entry index
DATA_W, 32, result/PC width

Ports:
clk  input  1  clock
rst  input  1  reset
rdy  input  1  global ready; low freezes all state
alloc_valid  input  1  dispatch requests a new entry this cycle
alloc_rd  input  5  destination register (0 = no writeback)
alloc_is_branch  input  1  entry is a conditional branch/jalr
alloc_pred_taken  input  1  predicted direction
alloc_pc  input  DATA_W  instruction PC (fall-through = pc+4)
alloc_tag  output  TAG_W  tag granted (current tail index)
full  output  1  no free entry
wb_valid  input  1  CDB broadcast valid
wb_tag  input  TAG_W  CDB tag
wb_value  input  DATA_W  CDB result
wb_taken  input  1  resolved branch direction
wb_target  input  DATA_W  resolved taken target
q1_tag, q2_tag  input  TAG_W  operand lookup tags
q1_ready, q2_ready  output  1  entry result available
q1_value, q2_value  output  DATA_W  entry result
commit_valid  output  1  register-file write strobe
commit_rd  output  5  committed destination
commit_tag  output  TAG_W  committed entry tag
commit_value  output  DATA_W  committed result
clr  output  1  flush pulse
redirect_pc  output  DATA_W  fetch restart PC, valid with clr

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On rst, head=tail=count=0 and all entries are not-ready.
- Outputs during rst and the cycle after: full=0, alloc_tag=0, commit_valid=0, clr=0, all commit/redirect/query outputs 0.
- Per-entry state: busy, ready, rd, is_branch, pred_taken, pc, value, taken, target.
- Allocation:
  - alloc_tag = tail (combinational). full = (count==ROB_SIZE), computed without commit bypass.
  - When alloc_valid && !full && !clr && rdy, the posedge writes the entry with busy=1, ready=0, then increments tail (wrapping mod ROB_SIZE).
  - alloc_valid while full or while clr is high is dropped.
- Writeback: when wb_valid && rdy, the posedge sets ready=1 and stores value/taken/target into entry wb_tag. A writeback to a non-busy entry is ignored.
- Query (combinational), for each of q1/q2:
  - If wb_valid && wb_tag==q_tag: ready=1, value=wb_value (same-cycle forward).
  - Else: ready and value come from the entry.
- Commit (combinational on the head entry):
  - commit_valid = rdy && count!=0 && head.ready && head.rd!=0.
  - commit_rd/tag/value come from the head entry; commit_tag=head.
  - No bypass: a head written back in cycle N commits in N+1. Max one commit per cycle.
- Retire: head retires when rdy && count!=0 && head.ready (also when rd=0). head increments (wrapping) and busy clears.
- Mispredict (combinational): the retiring head is a branch with taken!=pred_taken.
  - clr=1 in that same cycle, together with the commit of that head's rd/value.
  - redirect_pc = taken ? target : pc+4.
  - At that posedge: head=tail=count=0, all busy/ready cleared; concurrent alloc and wb are discarded.
- count: +1 on accepted alloc, -1 on retire, unchanged when both occur.
- rdy=0: no state change; commit_valid=0 and clr=0.
- Tags wrap: after tag 31 the next tag is 0.

Test Plan:
1. Reset, then alloc rd=5 at pc=0x100 (tag 0) and wb tag0 value=0xDEAD → the next cycle commit_valid=1, rd=5, tag=0, value=0xDEAD; then count returns to 0.
2. Alloc tags 0,1,2; wb tag2, then tag1, then tag0 → commits occur in order 0,1,2 on consecutive cycles, with none before tag0 is ready.
3. Alloc 32 entries → full=1, a 33rd alloc is dropped and alloc_tag stays at 0. Commit one entry while allocating → full stays 1, then the next alloc gets tag 0 (wrap).
4. Branch at pc=0x200, pred_taken=0, wb taken=1 target=0x400, two younger entries allocated → on the head commit cycle clr=1 and redirect_pc=0x400. The next cycle count=0 and alloc_tag=0; younger entries never commit.
5. q1_tag=3 with wb_valid tag3 value=7 in the same cycle → q1_ready=1 and q1_value=7. On a later cycle with no wb → the stored value 7 is returned.
6. rdy=0 while head is ready → commit_valid=0 and no pointer movement. rdy returns to 1 → the commit occurs. rst asserted with 5 entries in flight → all outputs 0 and count=0.

Source files
------------

// File: rtl/rob_commit_unit_if.sv
// Bundle of the dispatch, CDB, operand-query and commit/flush signals around the reorder buffer.
// master = core pipeline side, slave = reorder buffer.
interface rob_commit_unit_if #(
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32
);
  logic              alloc_valid;
  logic [4:0]        alloc_rd;
  logic              alloc_is_branch;
  logic              alloc_pred_taken;
  logic [DATA_W-1:0] alloc_pc;
  logic [TAG_W-1:0]  alloc_tag;
  logic              full;

  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_value;
  logic              wb_taken;
  logic [DATA_W-1:0] wb_target;

  logic [TAG_W-1:0]  q1_tag;
  logic [TAG_W-1:0]  q2_tag;
  logic              q1_ready;
  logic              q2_ready;
  logic [DATA_W-1:0] q1_value;
  logic [DATA_W-1:0] q2_value;

  logic              commit_valid;
  logic [4:0]        commit_rd;
  logic [TAG_W-1:0]  commit_tag;
  logic [DATA_W-1:0] commit_value;
  logic              clr;
  logic [DATA_W-1:0] redirect_pc;

  modport master (
    output alloc_valid, alloc_rd, alloc_is_branch, alloc_pred_taken, alloc_pc,
    output wb_valid, wb_tag, wb_value, wb_taken, wb_target,
    output q1_tag, q2_tag,
    input  alloc_tag, full, q1_ready, q2_ready, q1_value, q2_value,
    input  commit_valid, commit_rd, commit_tag, commit_value, clr, redirect_pc
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_is_branch, alloc_pred_taken, alloc_pc,
    input  wb_valid, wb_tag, wb_value, wb_taken, wb_target,
    input  q1_tag, q2_tag,
    output alloc_tag, full, q1_ready, q2_ready, q1_value, q2_value,
    output commit_valid, commit_rd, commit_tag, commit_value, clr, redirect_pc
  );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates tags at dispatch, collects CDB results, commits in program order
// and flushes the machine when a retiring branch turns out mispredicted.
module rob_commit_unit #(
  parameter int unsigned ROB_SIZE = 32,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned DATA_W   = 32
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  rob_commit_unit_if.slave bus
);
  localparam int unsigned CntW = TAG_W + 1;

  logic [ROB_SIZE-1:0] busy_q, ready_q, is_branch_q, pred_taken_q, taken_q;
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [DATA_W-1:0]   pc_q     [ROB_SIZE];
  logic [DATA_W-1:0]   value_q  [ROB_SIZE];
  logic [DATA_W-1:0]   target_q [ROB_SIZE];
  logic [TAG_W-1:0]    head_q, tail_q;
  logic [CntW-1:0]     count_q;

  logic full, retire, mispredict, alloc_ok, wb_ok;

  always_comb begin
    // full deliberately ignores a same-cycle retire
    full       = (count_q == CntW'(ROB_SIZE));
    retire     = rdy && !rst && (count_q != '0) && ready_q[head_q];
    mispredict = retire && is_branch_q[head_q] && (taken_q[head_q] != pred_taken_q[head_q]);
    alloc_ok   = bus.alloc_valid && !full && !mispredict && rdy && !rst;
    wb_ok      = bus.wb_valid && rdy && !rst && busy_q[bus.wb_tag];
  end

  always_comb begin
    bus.alloc_tag    = rst ? '0 : tail_q;
    bus.full         = !rst && full;
    bus.commit_valid = retire && (rd_q[head_q] != '0);
    bus.commit_rd    = rst ? '0 : rd_q[head_q];
    bus.commit_tag   = rst ? '0 : head_q;
    bus.commit_value = rst ? '0 : value_q[head_q];
    bus.clr          = mispredict;
    bus.redirect_pc  = '0;
    if (mispredict) begin
      bus.redirect_pc = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + DATA_W'(4);
    end
  end

  // Operand lookups forward a same-cycle CDB broadcast ahead of the stored entry.
  always_comb begin
    bus.q1_ready = 1'b0;
    bus.q1_value = '0;
    bus.q2_ready = 1'b0;
    bus.q2_value = '0;
    if (!rst) begin
      if (bus.wb_valid && (bus.wb_tag == bus.q1_tag)) begin
        bus.q1_ready = 1'b1;
        bus.q1_value = bus.wb_value;
      end else begin
        bus.q1_ready = ready_q[bus.q1_tag];
        bus.q1_value = value_q[bus.q1_tag];
      end
      if (bus.wb_valid && (bus.wb_tag == bus.q2_tag)) begin
        bus.q2_ready = 1'b1;
        bus.q2_value = bus.wb_value;
      end else begin
        bus.q2_ready = ready_q[bus.q2_tag];
        bus.q2_value = value_q[bus.q2_tag];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      ready_q      <= '0;
      is_branch_q  <= '0;
      pred_taken_q <= '0;
      taken_q      <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        value_q[i]  <= '0;
        target_q[i] <= '0;
      end
    end else if (mispredict) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
    end else if (rdy) begin
      if (wb_ok) begin
        ready_q[bus.wb_tag]  <= 1'b1;
        value_q[bus.wb_tag]  <= bus.wb_value;
        taken_q[bus.wb_tag]  <= bus.wb_taken;
        target_q[bus.wb_tag] <= bus.wb_target;
      end
      if (alloc_ok) begin
        busy_q[tail_q]       <= 1'b1;
        ready_q[tail_q]      <= 1'b0;
        rd_q[tail_q]         <= bus.alloc_rd;
        is_branch_q[tail_q]  <= bus.alloc_is_branch;
        pred_taken_q[tail_q] <= bus.alloc_pred_taken;
        pc_q[tail_q]         <= bus.alloc_pc;
        tail_q               <= tail_q + 1'b1;
      end
      // Placed after the writeback so a retiring entry always ends up idle.
      if (retire) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + CntW'(alloc_ok) - CntW'(retire);
    end
  end
endmodule
